// File: rtl/snake_cmd_scheduler_if.sv
// Bundle between the keyboard-event front end (master) and the command
// scheduler (slave): event pulses in, engine controls and status out.
interface snake_cmd_scheduler_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]        dir;
  logic              dir_vld;
  logic              sp_evt;
  logic              rst_evt;
  logic              tick;
  logic              game_over;
  logic [1:0]        cur_dir;
  logic              step;
  logic              game_rst;
  logic [1:0]        state;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output dir, dir_vld, sp_evt, rst_evt, tick, game_over,
    input  cur_dir, step, game_rst, state, fifo_cnt, drop_cnt
  );

  modport slave (
    input  dir, dir_vld, sp_evt, rst_evt, tick, game_over,
    output cur_dir, step, game_rst, state, fifo_cnt, drop_cnt
  );
endinterface

// File: rtl/snake_cmd_scheduler.sv
// Snake game-side scheduler: filters and queues direction requests, releases
// one per game tick as a step pulse, and runs the IDLE/RUN/PAUSE/OVER FSM.
module snake_cmd_scheduler #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snake_cmd_scheduler_if.slave  bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_cur_dir, r_last_dir;
  logic              r_step, r_game_rst;
  logic [DROP_W-1:0] r_drop;

  logic       w_flush, w_step, w_pop, w_push_req, w_legal, w_room, w_push, w_drop;
  logic [1:0] w_opp_last;

  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    if (bus.rst_evt) begin
      w_state_nxt = ST_IDLE;
      w_flush     = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (bus.sp_evt) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (bus.game_over)   w_state_nxt = ST_OVER;
          else if (bus.sp_evt) w_state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (bus.sp_evt) w_state_nxt = ST_RUN;
        ST_OVER: begin
          if (bus.sp_evt) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
          end
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reversal/redundancy check is against the last enqueued direction, not the
  // head; a pop in the same cycle frees a slot for a push into a full FIFO.
  always_comb begin
    w_opp_last = {r_last_dir[1], ~r_last_dir[0]};
    w_step     = !bus.rst_evt && (r_state == ST_RUN) && bus.tick && !bus.game_over;
    w_pop      = w_step && (r_cnt != '0);
    w_push_req = !bus.rst_evt && bus.dir_vld &&
                 ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    w_legal    = (bus.dir != r_last_dir) && (bus.dir != w_opp_last);
    w_room     = (r_cnt != FULL) || w_pop;
    w_push     = w_push_req && w_legal && w_room;
    w_drop     = w_push_req && !w_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_cur_dir  <= '0;
      r_last_dir <= '0;
      r_step     <= 1'b0;
      r_game_rst <= 1'b0;
      r_drop     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step;
      r_game_rst <= w_flush;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
      if (w_flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_cnt      <= '0;
        r_cur_dir  <= '0;
        r_last_dir <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= bus.dir;
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
          r_last_dir      <= bus.dir;
        end
        if (w_pop) begin
          r_cur_dir <= r_mem[r_rd_ptr];
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
        else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.cur_dir  = r_cur_dir;
  assign bus.step     = r_step;
  assign bus.game_rst = r_game_rst;
  assign bus.state    = r_state;
  assign bus.fifo_cnt = r_cnt;
  assign bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_snake_cmd_scheduler.sv
// Directed bench for snake_cmd_scheduler; expected step directions are queued
// as ticks are driven and checked by a monitor when step appears.
module tb_snake_cmd_scheduler;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_exp_steps;
  int   n_seen_steps;
  logic [1:0] exp_q [$];

  snake_cmd_scheduler_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  snake_cmd_scheduler #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step monitor: every step must match the next queued expected direction.
  always @(negedge clk) begin
    if (rst_n) begin
      check("step_and_game_rst_exclusive", {31'd0, bus.step & bus.game_rst}, 32'd0);
      if (bus.step) begin
        n_seen_steps++;
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'd1, 32'd0);
        end else begin
          check("step_cur_dir", {30'd0, bus.cur_dir}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.dir_vld = 1'b0;
    bus.sp_evt  = 1'b0;
    bus.rst_evt = 1'b0;
    bus.tick    = 1'b0;
  endtask

  task automatic sp();
    bus.sp_evt = 1'b1; cyc(); clear_in();
  endtask

  task automatic rst_key();
    bus.rst_evt = 1'b1; cyc(); clear_in();
  endtask

  task automatic push(input logic [1:0] d);
    bus.dir = d; bus.dir_vld = 1'b1; cyc(); clear_in();
  endtask

  task automatic tick_exp(input logic [1:0] exp_dir);
    exp_q.push_back(exp_dir);
    n_exp_steps++;
    bus.tick = 1'b1; cyc(); clear_in();
  endtask

  task automatic tick_none();
    bus.tick = 1'b1; cyc(); clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_exp_steps = 0; n_seen_steps = 0;
    rst_n = 1'b0;
    bus.dir = 2'b00; bus.game_over = 1'b0;
    clear_in();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("reset_state",    {30'd0, bus.state},    32'd0);
    check("reset_cur_dir",  {30'd0, bus.cur_dir},  32'd0);
    check("reset_fifo_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
    check("reset_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
    check("reset_step",     {31'd0, bus.step},     32'd0);

    // 1: start, single move
    push(2'b11);
    check("idle_push_ignored_cnt",  {29'd0, bus.fifo_cnt}, 32'd0);
    check("idle_push_ignored_drop", {24'd0, bus.drop_cnt}, 32'd0);
    sp();
    check("t1_state_run", {30'd0, bus.state}, 32'd1);
    push(2'b11);
    check("t1_fifo_cnt_1", {29'd0, bus.fifo_cnt}, 32'd1);
    tick_exp(2'b11);
    check("t1_step",      {31'd0, bus.step},     32'd1);
    check("t1_cur_dir",   {30'd0, bus.cur_dir},  32'd3);
    check("t1_fifo_cnt0", {29'd0, bus.fifo_cnt}, 32'd0);
    cyc();
    check("t1_step_one_cycle", {31'd0, bus.step}, 32'd0);

    // 2: reversal and redundant requests dropped
    push(2'b10);
    push(2'b11);
    check("t2_drop_cnt", {24'd0, bus.drop_cnt}, 32'd2);
    check("t2_fifo_cnt", {29'd0, bus.fifo_cnt}, 32'd0);

    // 3: fill FIFO, fifth rejected
    push(2'b00); push(2'b10); push(2'b01); push(2'b11); push(2'b00);
    check("t3_fifo_full", {29'd0, bus.fifo_cnt}, 32'd4);
    check("t3_drop_cnt",  {24'd0, bus.drop_cnt}, 32'd3);

    // 4: push and pop together on a full FIFO
    exp_q.push_back(2'b00);
    n_exp_steps++;
    bus.dir = 2'b01; bus.dir_vld = 1'b1; bus.tick = 1'b1; cyc(); clear_in();
    check("t4_cnt_stays_full", {29'd0, bus.fifo_cnt}, 32'd4);
    check("t4_drop_unchanged", {24'd0, bus.drop_cnt}, 32'd3);
    check("t4_cur_dir",        {30'd0, bus.cur_dir},  32'd0);
    tick_exp(2'b10); tick_exp(2'b01); tick_exp(2'b11); tick_exp(2'b01);
    check("t4_drained", {29'd0, bus.fifo_cnt}, 32'd0);
    tick_exp(2'b01);
    check("empty_tick_cur_dir", {30'd0, bus.cur_dir}, 32'd1);

    // 5: game over beats tick and sp_evt
    bus.game_over = 1'b1; bus.tick = 1'b1; bus.sp_evt = 1'b1; cyc(); clear_in();
    check("t5_state_over", {30'd0, bus.state}, 32'd3);
    check("t5_no_step",    {31'd0, bus.step},  32'd0);
    bus.game_over = 1'b0;
    tick_none();
    check("t5_over_tick_no_step", {31'd0, bus.step}, 32'd0);
    sp();
    check("t5_state_idle",  {30'd0, bus.state},    32'd0);
    check("t5_game_rst",    {31'd0, bus.game_rst}, 32'd1);
    check("t5_cur_dir_clr", {30'd0, bus.cur_dir},  32'd0);
    check("t5_fifo_clr",    {29'd0, bus.fifo_cnt}, 32'd0);
    cyc();
    check("t5_game_rst_pulse", {31'd0, bus.game_rst}, 32'd0);

    // 6: pause holds queue, rst_evt flushes, drop counter saturates
    sp();
    push(2'b10); push(2'b01);
    check("t6_two_queued", {29'd0, bus.fifo_cnt}, 32'd2);
    sp();
    check("t6_pause", {30'd0, bus.state}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick_none();
      check("t6_pause_no_step", {31'd0, bus.step}, 32'd0);
    end
    check("t6_pause_cnt", {29'd0, bus.fifo_cnt}, 32'd2);
    rst_key();
    check("t6_idle",     {30'd0, bus.state},    32'd0);
    check("t6_game_rst", {31'd0, bus.game_rst}, 32'd1);
    check("t6_flushed",  {29'd0, bus.fifo_cnt}, 32'd0);
    check("t6_drop_kept", {24'd0, bus.drop_cnt}, 32'd3);
    sp();
    bus.dir = 2'b00; bus.dir_vld = 1'b1;
    repeat (250) cyc();
    check("t6_drop_253", {24'd0, bus.drop_cnt}, 32'd253);
    repeat (50) cyc();
    clear_in();
    check("t6_drop_sat", {24'd0, bus.drop_cnt}, 32'd255);

    // async reset suppresses a pending step
    push(2'b10);
    bus.tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, bus.state},    32'd0);
    check("arst_drop",  {24'd0, bus.drop_cnt}, 32'd0);
    check("arst_cnt",   {29'd0, bus.fifo_cnt}, 32'd0);
    cyc(); clear_in();
    check("arst_no_step", {31'd0, bus.step}, 32'd0);
    rst_n = 1'b1;
    cyc();

    check("step_count", n_seen_steps, n_exp_steps);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
